// File: rtl/apb_multi_slave_top.sv
`default_nettype none
// ============================================================================
//  Module      : apb_multi_slave_top
//  Description : Button-triggered APB master, address decoder and
//                NUM_SLAVES wait-state register-bank slaves with status LEDs.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_multi_slave_top #(
    parameter int NUM_SLAVES     = 4,
    parameter int REGS_PER_SLAVE = 4,
    parameter int WAIT_CYCLES    = 0,
    parameter int TIMEOUT        = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        btn_go,
    input  logic [15:0] SW,
    output logic [15:0] LED,
    output logic        busy,
    output logic        err
);

    localparam int         c_RB       = (REGS_PER_SLAVE > 1) ? $clog2(REGS_PER_SLAVE) : 0;
    localparam int         c_IW       = (c_RB > 0) ? c_RB : 1;
    localparam logic [7:0] c_WAIT     = 8'(WAIT_CYCLES);
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;

    logic [1:0]  r_state_q,   w_state_d;
    logic        r_btn_q,     w_btn_d;
    logic [6:0]  r_paddr_q,   w_paddr_d;
    logic [31:0] r_pwdata_q,  w_pwdata_d;
    logic        r_pwrite_q,  w_pwrite_d;
    logic [15:0] r_tmo_q,     w_tmo_d;
    logic        r_err_q,     w_err_d;
    logic        r_led_err_q, w_led_err_d;
    logic        r_led_wr_q,  w_led_wr_d;
    logic [7:0]  r_led_rd_q,  w_led_rd_d;

    logic                  w_psel;
    logic                  w_penable;
    logic                  w_trigger;
    logic [6:0]            w_slv_idx;
    logic [c_IW-1:0]       w_reg_idx;
    logic                  w_slv_valid;
    logic [NUM_SLAVES-1:0] w_psel_x;
    logic [NUM_SLAVES-1:0] w_slv_pready;
    logic [31:0]           w_slv_prdata [NUM_SLAVES];
    logic                  w_pready;
    logic                  w_pslverr;
    logic [31:0]           w_prdata;
    logic                  w_unused_prdata;

    assign w_psel    = (r_state_q != c_ST_IDLE);
    assign w_penable = (r_state_q == c_ST_ACCESS);
    assign w_trigger = btn_go & ~r_btn_q & ~w_psel;

    assign w_slv_idx   = r_paddr_q >> c_RB;
    assign w_reg_idx   = r_paddr_q[c_IW-1:0] & c_IW'(REGS_PER_SLAVE - 1);
    assign w_slv_valid = (w_slv_idx < 7'(NUM_SLAVES));

    always_comb begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_psel_x[i] = w_psel && w_slv_valid && (w_slv_idx == 7'(i));
        end
    end

    // Unmapped addresses complete at once with an error and zero read data.
    always_comb begin
        w_pready  = 1'b1;
        w_pslverr = ~w_slv_valid;
        w_prdata  = 32'd0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_psel_x[i]) begin
                w_pready = w_slv_pready[i];
                w_prdata = w_slv_prdata[i];
            end
        end
    end

    assign w_unused_prdata = ^w_prdata[31:8];

    always_comb begin
        w_state_d   = r_state_q;
        w_btn_d     = btn_go;
        w_paddr_d   = r_paddr_q;
        w_pwdata_d  = r_pwdata_q;
        w_pwrite_d  = r_pwrite_q;
        w_tmo_d     = r_tmo_q;
        w_err_d     = r_err_q;
        w_led_err_d = r_led_err_q;
        w_led_wr_d  = r_led_wr_q;
        w_led_rd_d  = r_led_rd_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (w_trigger) begin
                    w_state_d  = c_ST_SETUP;
                    w_paddr_d  = SW[14:8];
                    w_pwdata_d = {4{SW[7:0]}};
                    w_pwrite_d = SW[15];
                end
            end
            c_ST_SETUP: begin
                w_state_d = c_ST_ACCESS;
                w_tmo_d   = 16'd0;
            end
            c_ST_ACCESS: begin
                if (w_pready) begin
                    w_state_d   = c_ST_IDLE;
                    w_err_d     = w_pslverr;
                    w_led_err_d = w_pslverr;
                    w_led_wr_d  = r_pwrite_q;
                    if (!r_pwrite_q && !w_pslverr) begin
                        w_led_rd_d = w_prdata[7:0];
                    end
                end else if (r_tmo_q == c_TMO_LAST) begin
                    w_state_d   = c_ST_IDLE;
                    w_err_d     = 1'b1;
                    w_led_err_d = 1'b1;
                end else begin
                    w_tmo_d = r_tmo_q + 16'd1;
                end
            end
            default: w_state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state_q   <= c_ST_IDLE;
            r_btn_q     <= 1'b1;
            r_paddr_q   <= 7'd0;
            r_pwdata_q  <= 32'd0;
            r_pwrite_q  <= 1'b0;
            r_tmo_q     <= 16'd0;
            r_err_q     <= 1'b0;
            r_led_err_q <= 1'b0;
            r_led_wr_q  <= 1'b0;
            r_led_rd_q  <= 8'd0;
        end else begin
            r_state_q   <= w_state_d;
            r_btn_q     <= w_btn_d;
            r_paddr_q   <= w_paddr_d;
            r_pwdata_q  <= w_pwdata_d;
            r_pwrite_q  <= w_pwrite_d;
            r_tmo_q     <= w_tmo_d;
            r_err_q     <= w_err_d;
            r_led_err_q <= w_led_err_d;
            r_led_wr_q  <= w_led_wr_d;
            r_led_rd_q  <= w_led_rd_d;
        end
    end

    generate
        for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slave
            logic [7:0]  r_wait_q, w_wait_d;
            logic [31:0] r_regs_q [REGS_PER_SLAVE];
            logic [31:0] w_regs_d [REGS_PER_SLAVE];
            logic        w_ready;

            assign w_ready         = (r_wait_q == 8'd0);
            assign w_slv_pready[s] = w_ready;
            assign w_slv_prdata[s] = (w_psel_x[s] && w_penable && !r_pwrite_q && w_ready)
                                     ? r_regs_q[w_reg_idx] : 32'd0;

            // Counter reloads during SETUP and clears whenever deselected.
            always_comb begin
                w_regs_d = r_regs_q;
                w_wait_d = r_wait_q;
                if (!w_psel_x[s]) begin
                    w_wait_d = 8'd0;
                end else if (!w_penable) begin
                    w_wait_d = c_WAIT;
                end else if (!w_ready) begin
                    w_wait_d = r_wait_q - 8'd1;
                end
                if (w_psel_x[s] && w_penable && r_pwrite_q && w_ready) begin
                    w_regs_d[w_reg_idx] = r_pwdata_q;
                end
            end

            always_ff @(posedge PCLK) begin
                if (PRESET) begin
                    r_wait_q <= 8'd0;
                    for (int i = 0; i < REGS_PER_SLAVE; i++) begin
                        r_regs_q[i] <= 32'd0;
                    end
                end else begin
                    r_wait_q <= w_wait_d;
                    r_regs_q <= w_regs_d;
                end
            end
        end
    endgenerate

    assign LED  = {r_led_err_q, r_led_wr_q, 6'd0, r_led_rd_q};
    assign busy = w_psel;
    assign err  = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_multi_slave_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_multi_slave_top
//  Description : Directed bench; three instances cover no-wait, 3-wait and
//                timeout configurations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_multi_slave_top;

    logic        clk;
    logic        rst;
    logic [2:0]  btn;
    logic [15:0] sw;
    logic [15:0] led [3];
    logic [2:0]  busy;
    logic [2:0]  err;

    int n_checks;
    int n_pass;
    int cyc;
    int busy_cnt;

    apb_multi_slave_top #(.NUM_SLAVES(4), .REGS_PER_SLAVE(4), .WAIT_CYCLES(0), .TIMEOUT(16)) dut0 (
        .PCLK(clk), .PRESET(rst), .btn_go(btn[0]), .SW(sw), .LED(led[0]), .busy(busy[0]), .err(err[0]));
    apb_multi_slave_top #(.NUM_SLAVES(4), .REGS_PER_SLAVE(4), .WAIT_CYCLES(3), .TIMEOUT(16)) dut3 (
        .PCLK(clk), .PRESET(rst), .btn_go(btn[1]), .SW(sw), .LED(led[1]), .busy(busy[1]), .err(err[1]));
    apb_multi_slave_top #(.NUM_SLAVES(4), .REGS_PER_SLAVE(4), .WAIT_CYCLES(20), .TIMEOUT(16)) dut20 (
        .PCLK(clk), .PRESET(rst), .btn_go(btn[2]), .SW(sw), .LED(led[2]), .busy(busy[2]), .err(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Returns the number of cycles busy was high for one transfer.
    task automatic xfer(input int d, input logic [15:0] s, output int cycles);
        sw     = s;
        btn[d] = 1'b1;
        cycles = 0;
        tick();
        while (busy[d] && cycles < 64) begin
            cycles++;
            tick();
        end
        btn[d] = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        btn      = 3'b111;
        sw       = 16'h0000;
        repeat (3) tick();
        check_val("rst_led", {16'd0, led[0]}, 32'h0);
        check_val("rst_err", {31'd0, err[0]}, 32'h0);
        check_val("rst_busy", {29'd0, busy}, 32'h0);

        // Button held high through reset release must not start a transfer.
        rst      = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy != 3'b000) busy_cnt++;
        end
        check_val("held_btn_no_xfer", busy_cnt, 0);
        btn = 3'b000;
        tick();

        // No wait states
        xfer(0, 16'h0000, cyc);
        check_val("rd0_cycles", cyc, 2);
        check_val("rd0_led", {16'd0, led[0]}, 32'h0000);
        check_val("rd0_err", {31'd0, err[0]}, 32'h0);

        xfer(0, 16'h7F00, cyc);
        check_val("dec_cycles", cyc, 2);
        check_val("dec_led", {16'd0, led[0]}, 32'h8000);
        check_val("dec_err", {31'd0, err[0]}, 32'h1);

        xfer(0, 16'h8D5A, cyc);
        check_val("wr0_led", {16'd0, led[0]}, 32'h4000);
        check_val("wr0_err", {31'd0, err[0]}, 32'h0);
        xfer(0, 16'h0D00, cyc);
        check_val("rd0b_led", {16'd0, led[0]}, 32'h005A);
        xfer(0, 16'h0C00, cyc);
        check_val("rd0c_other_reg", {16'd0, led[0]}, 32'h0000);

        // Three wait states
        xfer(1, 16'h85A5, cyc);
        check_val("wr3_cycles", cyc, 5);
        check_val("wr3_led", {16'd0, led[1]}, 32'h4000);
        check_val("wr3_err", {31'd0, err[1]}, 32'h0);
        xfer(1, 16'h0500, cyc);
        check_val("rd3_cycles", cyc, 5);
        check_val("rd3_led", {16'd0, led[1]}, 32'h00A5);
        check_val("rd3_err", {31'd0, err[1]}, 32'h0);

        // Extra edge while busy is dropped
        sw       = 16'h0500;
        btn[1]   = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy[1]) busy_cnt++;
            btn[1] = (i == 1);
        end
        check_val("busy_edge_one_xfer", busy_cnt, 5);
        btn[1] = 1'b0;
        tick();

        // Timeout abort
        xfer(2, 16'h8077, cyc);
        check_val("tmo_wr_cycles", cyc, 17);
        check_val("tmo_wr_err", {31'd0, err[2]}, 32'h1);
        check_val("tmo_wr_led", {16'd0, led[2]}, 32'h8000);
        check_val("tmo_reg_uncommitted", dut20.g_slave[0].r_regs_q[0], 32'h0);
        xfer(2, 16'h0000, cyc);
        check_val("tmo_rd_cycles", cyc, 17);
        check_val("tmo_rd_led", {16'd0, led[2]}, 32'h8000);

        // Reset in the middle of ACCESS of a write
        sw     = 16'h8233;
        btn[1] = 1'b1;
        tick();
        tick();
        tick();
        check_val("pre_rst_busy", {31'd0, busy[1]}, 32'h1);
        rst = 1'b1;
        tick();
        check_val("mid_rst_busy", {31'd0, busy[1]}, 32'h0);
        check_val("mid_rst_led", {16'd0, led[1]}, 32'h0);
        check_val("mid_rst_err", {31'd0, err[1]}, 32'h0);
        check_val("mid_rst_reg", dut3.g_slave[0].r_regs_q[2], 32'h0);
        check_val("mid_rst_reg_prev", dut3.g_slave[1].r_regs_q[1], 32'h0);
        rst    = 1'b0;
        btn[1] = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
